// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants and types for the LC-3b ALU issue slice.
//   - ALU operation codes (ADD/AND/XOR/PASSA), also used by the ALU itself
//   - LC-3b opcode constants for the operations decoded here
//   - issue_t: one decoded entry as it sits in the output and skid registers
package alu_issue_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_XOR   = 2'b10,
    ALU_PASSA = 2'b11
  } alu_op_e;

  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_AND = 4'b0101;
  localparam logic [3:0] OPC_XOR = 4'b1001;
  localparam logic [3:0] OPC_LEA = 4'b1110;

  typedef struct packed {
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    alu_op_e     alu_op;
    logic [2:0]  dr;
    logic        wb_en;
    logic        setcc;
  } issue_t;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec: purely combinational decode of one LC-3b instruction into
// ALU operands, ALU code, destination and write-back/condition-code flags.
//   ir        in  16  instruction word
//   sr1_data  in  16  register-file read value for SR1
//   sr2_data  in  16  register-file read value for SR2
//   dec       out     decoded entry (issue_t)
//   illegal   out  1  opcode not handled by this ALU slice
//                     (present only when ALU_ISSUE_ILLEGAL_EN is defined)
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [15:0] sr1_data,
  input  logic [15:0] sr2_data,
  output issue_t      dec
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  logic arith;
  // SR1 field is consumed by the register file, not by this decoder.
  logic unused_sr1_field;
  assign unused_sr1_field = ^ir[8:6];

  always_comb begin
    arith       = 1'b0;
    dec.alu_a   = sr1_data;
    dec.alu_b   = '0;
    dec.alu_op  = ALU_PASSA;
    dec.dr      = ir[11:9];
    dec.wb_en   = 1'b0;
    dec.setcc   = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
    illegal     = 1'b0;
`endif
    case (ir[15:12])
      OPC_ADD: begin
        arith      = 1'b1;
        dec.alu_op = ALU_ADD;
      end
      OPC_AND: begin
        arith      = 1'b1;
        dec.alu_op = ALU_AND;
      end
      OPC_XOR: begin
        arith      = 1'b1;
        dec.alu_op = ALU_XOR;
      end
      OPC_LEA: begin
        dec.wb_en  = 1'b1;
      end
      default: begin
`ifdef ALU_ISSUE_ILLEGAL_EN
        illegal    = 1'b1;
`endif
      end
    endcase
    if (arith) begin
      dec.alu_b = ir[5] ? sext5(ir[4:0]) : sr2_data;
      dec.wb_en = 1'b1;
      dec.setcc = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode stage -> execute stage issue register with a one-entry
// skid buffer. One-cycle latency, strict FIFO order, flush kills both entries.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake (in_ready = !skid_valid)
//   in_ir, sr1_data, sr2_data  instruction and register-file operands
//   flush                 discard held entries and the input of this cycle
//   out_valid/out_ready   downstream handshake
//   alu_a, alu_b, alu_op, dr, wb_en, setcc  issued entry
//   out_illegal           unhandled opcode flag; exists only when the macro
//                         ALU_ISSUE_ILLEGAL_EN is defined
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_ir,
  input  logic [15:0] sr1_data,
  input  logic [15:0] sr2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  output logic [2:0]  dr,
  output logic        wb_en,
  output logic        setcc
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic        out_illegal
`endif
);

  issue_t dec;
  issue_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, load_out;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic dec_ill, out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
`endif

  alu_issue_dec u_dec (
    .ir       (in_ir),
    .sr1_data (sr1_data),
    .sr2_data (sr2_data),
    .dec      (dec)
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    .illegal  (dec_ill)
`endif
  );

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign load_out = !out_valid_q || out_ready;

  // Skid is only ever filled while the output is held, so skid_valid
  // implies out_valid and the skid entry is always the younger one.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
    out_ill_d    = out_ill_q;
    skid_ill_d   = skid_ill_q;
`endif
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (load_out) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
        out_ill_d    = skid_ill_q;
`endif
      end else if (accept) begin
        out_d        = dec;
        out_valid_d  = 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_EN
        out_ill_d    = dec_ill;
`endif
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_EN
      skid_ill_d   = dec_ill;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      out_ill_q    <= 1'b0;
      skid_ill_q   <= 1'b0;
`endif
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
      out_ill_q    <= out_ill_d;
      skid_ill_q   <= skid_ill_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = out_q.alu_a;
  assign alu_b     = out_q.alu_b;
  assign alu_op    = out_q.alu_op;
  assign dr        = out_q.dr;
  assign wb_en     = out_q.wb_en;
  assign setcc     = out_q.setcc;
`ifdef ALU_ISSUE_ILLEGAL_EN
  // Qualified so the flag never shows without a valid entry.
  assign out_illegal = out_ill_q && out_valid_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk, rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] in_ir, sr1_data, sr2_data, alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [2:0]  dr;
  logic        wb_en, setcc;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        out_illegal;
`endif

  int total = 0;
  int bad   = 0;

  alu_issue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ir     (in_ir),
    .sr1_data  (sr1_data),
    .sr2_data  (sr2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .dr        (dr),
    .wb_en     (wb_en),
    .setcc     (setcc)
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    .out_illegal (out_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one decoded entry, computed straight from the opcode table.
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [2:0]  dr;
    logic        wb;
    logic        sc;
    logic        ill;
  } exp_t;

  exp_t q[$];  // entries held by the block, oldest first

  function automatic exp_t model_dec(input logic [15:0] ir, input logic [15:0] s1,
                                     input logic [15:0] s2);
    exp_t e;
    logic [15:0] imm;
    imm  = ir[4] ? 16'(ir[4:0]) - 16'd32 : 16'(ir[4:0]);
    e.a  = s1;
    e.b  = 16'd0;
    e.op = 2'd3;
    e.dr = ir[11:9];
    e.wb = 1'b0;
    e.sc = 1'b0;
    e.ill = 1'b0;
    case (ir[15:12])
      4'h1, 4'h5, 4'h9: begin
        e.op = (ir[15:12] == 4'h1) ? 2'd0 : (ir[15:12] == 4'h5) ? 2'd1 : 2'd2;
        e.b  = ir[5] ? imm : s2;
        e.wb = 1'b1;
        e.sc = 1'b1;
      end
      4'hE: e.wb = 1'b1;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Model update: a FIFO of at most two entries.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst || flush) begin
        q.delete();
      end else if (in_valid && q.size() < 2) begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        q.push_back(model_dec(in_ir, sr1_data, sr2_data));
      end else if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
      end
    end
  end

  // Compare process, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0 && out_valid) begin
          chk("alu_a", 32'(alu_a), 32'(q[0].a));
          chk("alu_b", 32'(alu_b), 32'(q[0].b));
          chk("alu_op", 32'(alu_op), 32'(q[0].op));
          chk("dr", 32'(dr), 32'(q[0].dr));
          chk("wb_en", 32'(wb_en), 32'(q[0].wb));
          chk("setcc", 32'(setcc), 32'(q[0].sc));
`ifdef ALU_ISSUE_ILLEGAL_EN
          chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_a"}, 32'(alu_a), 32'd0);
    chk({nm, "_b"}, 32'(alu_b), 32'd0);
    chk({nm, "_op"}, 32'(alu_op), 32'd0);
    chk({nm, "_dr"}, 32'(dr), 32'd0);
    chk({nm, "_wb"}, 32'(wb_en), 32'd0);
    chk({nm, "_sc"}, 32'(setcc), 32'd0);
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk({nm, "_ill"}, 32'(out_illegal), 32'd0);
`endif
  endtask

  logic [11:0] low;
  logic [3:0]  opc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_ir = '0; sr1_data = '0; sr2_data = '0;
    #12;
    chk_all_zero("reset");
    rst = 1'b0;

    // ADD immediate, output held afterwards
    in_valid = 1'b1; in_ir = 16'h1261; sr1_data = 16'h0005; sr2_data = 16'hAAAA;
    step();
    chk("add_imm_valid", 32'(out_valid), 32'd1);
    chk("add_imm_a", 32'(alu_a), 32'h5);
    chk("add_imm_b", 32'(alu_b), 32'h1);
    chk("add_imm_op", 32'(alu_op), 32'd0);
    chk("add_imm_dr", 32'(dr), 32'd1);
    chk("add_imm_wb", 32'(wb_en), 32'd1);
    chk("add_imm_sc", 32'(setcc), 32'd1);
    // second ADD (register form) lands in skid
    in_ir = 16'h1401; sr1_data = 16'h0007; sr2_data = 16'h0009;
    step();
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_a", 32'(alu_a), 32'h5);
    in_valid = 1'b0;
    step();
    chk("bp_stable_a", 32'(alu_a), 32'h5);
    out_ready = 1'b1;
    step();
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_a", 32'(alu_a), 32'h7);
    chk("bp_second_b", 32'(alu_b), 32'h9);
    chk("bp_second_dr", 32'(dr), 32'd2);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // NOT via XOR with imm -1
    in_valid = 1'b1; in_ir = 16'h967F; sr1_data = 16'h00F0;
    step();
    in_valid = 1'b0;
    chk("xor_b", 32'(alu_b), 32'hFFFF);
    chk("xor_op", 32'(alu_op), 32'd2);
    chk("xor_dr", 32'(dr), 32'd3);
    step();

    // Flush with both entries full and a pending input
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 16'h1261; sr1_data = 16'h0001;
    step();
    step();
    chk("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_quiet", 32'(out_valid), 32'd0);
    end

    // BR: unhandled opcode
    in_valid = 1'b1; in_ir = 16'h0E02; sr1_data = 16'h1234;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("br_op", 32'(alu_op), 32'd3);
    chk("br_wb", 32'(wb_en), 32'd0);
    chk("br_sc", 32'(setcc), 32'd0);
    chk("br_b", 32'(alu_b), 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("br_ill", 32'(out_illegal), 32'd1);
`endif
    step();

    // Asynchronous reset while an entry is held
    #2 rst = 1'b1;
    #1 chk_all_zero("arst");
    #2 rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("arst_nopulse", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_ir = 16'h1261; sr1_data = 16'h0005;
    step();
    in_valid = 1'b0;
    chk("arst_resume_valid", 32'(out_valid), 32'd1);
    chk("arst_resume_a", 32'(alu_a), 32'h5);
    step();
    chk("arst_resume_done", 32'(out_valid), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 4))
        0: opc = 4'h1;
        1: opc = 4'h5;
        2: opc = 4'h9;
        3: opc = 4'hE;
        default: opc = 4'($urandom);
      endcase
      low      = 12'($urandom);
      in_ir    = {opc, low};
      sr1_data = 16'($urandom);
      sr2_data = 16'($urandom);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
